// File: rtl/clint_timer.sv
// Multi-hart CLINT: shared prescaled 64-bit mtime, per-hart mtimecmp/msip, SRAM-style 32-bit bus.
// Read data, mtip and msip are registered (one-cycle latency); no backpressure, every access completes in one cycle.
module clint_timer #(
  parameter int NUM_HARTS    = 2,
  parameter int PRESCALE_W   = 16,
  parameter int PRESCALE_RST = 100,
  parameter int ADDR_W       = 7
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 csb_i,
  input  logic                 wen_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [31:0]          data_i,
  input  logic [3:0]           wmask_i,
  output logic [31:0]          data_o,
  output logic [NUM_HARTS-1:0] mtip_o,
  output logic [NUM_HARTS-1:0] msip_o
);

  localparam int WW = ADDR_W - 2;

  logic [63:0]           mtime;
  logic [31:0]           shadow;
  logic                  en;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] cnt;
  logic [NUM_HARTS-1:0]  msip;
  logic [63:0]           mtimecmp [NUM_HARTS];

  logic [WW-1:0]         word;
  logic                  wr, rd, tick;
  logic                  sel_lo, sel_hi, sel_ctrl, sel_ps;
  logic [NUM_HARTS-1:0]  sel_msip, sel_cmp_lo, sel_cmp_hi;
  logic [31:0]           rdata;
  logic                  addr_unused;

  assign addr_unused = ^addr_i[1:0];
  assign word        = addr_i[ADDR_W-1:2];
  assign wr          = !csb_i && !wen_i;
  assign rd          = !csb_i && wen_i;
  assign sel_lo      = (word == WW'(0));
  assign sel_hi      = (word == WW'(1));
  assign sel_ctrl    = (word == WW'(2));
  assign sel_ps      = (word == WW'(3));

  // PRESCALE of 0 or 1 degenerates to a tick every enabled cycle.
  assign tick = en && ((prescale <= PRESCALE_W'(1)) || (cnt == prescale - PRESCALE_W'(1)));

  function automatic logic [31:0] wmerge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = m[b] ? d[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  always_comb begin
    sel_msip   = '0;
    sel_cmp_lo = '0;
    sel_cmp_hi = '0;
    rdata      = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      sel_msip[h]   = (word == WW'(4 + h));
      sel_cmp_lo[h] = (word == WW'(16 + 2*h));
      sel_cmp_hi[h] = (word == WW'(17 + 2*h));
    end
    if (sel_lo)   rdata = mtime[31:0];
    if (sel_hi)   rdata = shadow;
    if (sel_ctrl) rdata = {31'b0, en};
    if (sel_ps)   rdata = 32'(prescale);
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (sel_msip[h])   rdata = {31'b0, msip[h]};
      if (sel_cmp_lo[h]) rdata = mtimecmp[h][31:0];
      if (sel_cmp_hi[h]) rdata = mtimecmp[h][63:32];
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      mtime    <= '0;
      shadow   <= '0;
      en       <= 1'b1;
      prescale <= PRESCALE_W'(PRESCALE_RST);
      cnt      <= '0;
      msip     <= '0;
      data_o   <= '0;
      mtip_o   <= '0;
      msip_o   <= '0;
      for (int h = 0; h < NUM_HARTS; h++) mtimecmp[h] <= '1;
    end else begin
      if (wr && sel_ps)  cnt <= '0;
      else if (en)       cnt <= tick ? '0 : cnt + PRESCALE_W'(1);

      // A write to either half swallows the tick for the whole 64-bit counter.
      if (wr && sel_lo)       mtime[31:0]  <= wmerge(mtime[31:0], data_i, wmask_i);
      else if (wr && sel_hi)  mtime[63:32] <= wmerge(mtime[63:32], data_i, wmask_i);
      else if (tick)          mtime        <= mtime + 64'd1;

      if (rd && sel_lo)       shadow <= mtime[63:32];
      else if (wr && sel_hi)  shadow <= wmerge(shadow, data_i, wmask_i);

      if (wr && sel_ctrl && wmask_i[0]) en <= data_i[0];
      if (wr && sel_ps) prescale <= PRESCALE_W'(wmerge(32'(prescale), data_i, wmask_i));

      for (int h = 0; h < NUM_HARTS; h++) begin
        if (wr && sel_msip[h] && wmask_i[0]) msip[h] <= data_i[0];
        if (wr && sel_cmp_lo[h])
          mtimecmp[h][31:0]  <= wmerge(mtimecmp[h][31:0], data_i, wmask_i);
        if (wr && sel_cmp_hi[h])
          mtimecmp[h][63:32] <= wmerge(mtimecmp[h][63:32], data_i, wmask_i);
        mtip_o[h] <= (mtime >= mtimecmp[h]);
      end
      msip_o <= msip;

      if (rd) data_o <= rdata;
    end
  end

endmodule

// File: tb/tb_clint_timer.sv
// Self-checking bench for clint_timer: directed scenarios plus randomized traffic vs a reference model.
module tb_clint_timer;
  localparam int NH = 2;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          csb_i, wen_i;
  logic [6:0]    addr_i;
  logic [31:0]   data_i;
  logic [3:0]    wmask_i;
  logic [31:0]   data_o;
  logic [NH-1:0] mtip_o, msip_o;

  int checks = 0;
  int fails  = 0;

  clint_timer #(.NUM_HARTS(NH), .PRESCALE_W(16), .PRESCALE_RST(100), .ADDR_W(7)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .csb_i(csb_i), .wen_i(wen_i), .addr_i(addr_i),
    .data_i(data_i), .wmask_i(wmask_i), .data_o(data_o), .mtip_o(mtip_o), .msip_o(msip_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: mtime advances once every PRESCALE enabled cycles counted since the last PRESCALE write.
  logic [63:0]   m_time;
  logic [31:0]   m_shadow;
  logic          m_en;
  logic [15:0]   m_ps;
  longint        m_ecyc;
  logic          m_msip [NH];
  logic [63:0]   m_cmp  [NH];
  logic [31:0]   exp_data;
  logic [NH-1:0] exp_mtip, exp_msip;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = m[b] ? d[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input int off);
    if (off == 0)  return m_time[31:0];
    if (off == 4)  return m_shadow;
    if (off == 8)  return {31'b0, m_en};
    if (off == 12) return {16'b0, m_ps};
    for (int h = 0; h < NH; h++) begin
      if (off == 16 + 4*h) return {31'b0, m_msip[h]};
      if (off == 64 + 8*h) return m_cmp[h][31:0];
      if (off == 68 + 8*h) return m_cmp[h][63:32];
    end
    return 32'd0;
  endfunction

  task automatic model_reset();
    m_time = 0; m_shadow = 0; m_en = 1; m_ps = 100; m_ecyc = 0;
    exp_data = 0; exp_mtip = 0; exp_msip = 0;
    for (int h = 0; h < NH; h++) begin m_msip[h] = 0; m_cmp[h] = '1; end
  endtask

  task automatic model_step();
    int     off;
    bit     w, r, tick, en_pre;
    longint eff;
    off    = int'({addr_i[6:2], 2'b00});
    w      = !csb_i && !wen_i;
    r      = !csb_i && wen_i;
    en_pre = m_en;
    eff    = (m_ps < 2) ? 64'd1 : longint'(m_ps);
    tick   = m_en && (((m_ecyc + 1) % eff) == 0);
    for (int h = 0; h < NH; h++) begin
      exp_mtip[h] = (m_time >= m_cmp[h]);
      exp_msip[h] = m_msip[h];
    end
    if (r) begin
      exp_data = model_read(off);
      if (off == 0) m_shadow = m_time[63:32];
    end
    if (w) begin
      if (off == 0) m_time[31:0] = merge(m_time[31:0], data_i, wmask_i);
      if (off == 4) begin
        m_time[63:32] = merge(m_time[63:32], data_i, wmask_i);
        m_shadow      = merge(m_shadow, data_i, wmask_i);
      end
      if (off == 8 && wmask_i[0]) m_en = data_i[0];
      if (off == 12) m_ps = merge({16'b0, m_ps}, data_i, wmask_i) & 32'hFFFF;
      for (int h = 0; h < NH; h++) begin
        if (off == 16 + 4*h && wmask_i[0]) m_msip[h] = data_i[0];
        if (off == 64 + 8*h) m_cmp[h][31:0]  = merge(m_cmp[h][31:0], data_i, wmask_i);
        if (off == 68 + 8*h) m_cmp[h][63:32] = merge(m_cmp[h][63:32], data_i, wmask_i);
      end
    end
    if (!(w && (off == 0 || off == 4)) && tick) m_time = m_time + 1;
    if (w && off == 12) m_ecyc = 0;
    else if (en_pre)    m_ecyc = m_ecyc + 1;
  endtask

  always @(posedge clk_i) if (reset_i) model_step();

  // Bus tasks: entered at a negedge, consume exactly one clock edge, return at the next negedge.
  task automatic wr_reg(input int a, input logic [31:0] d, input logic [3:0] m);
    csb_i = 0; wen_i = 0; addr_i = 7'(a); data_i = d; wmask_i = m;
    @(negedge clk_i);
    csb_i = 1; wen_i = 1;
  endtask

  task automatic rd_reg(input int a, output logic [31:0] d);
    csb_i = 0; wen_i = 1; addr_i = 7'(a);
    @(negedge clk_i);
    csb_i = 1;
    d = data_o;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    checks++; if (data_o !== 32'd0 || mtip_o !== '0 || msip_o !== '0) begin
      fails++; $display("FAIL reset_outputs: got data=%h mtip=%b msip=%b expected all zero", data_o, mtip_o, msip_o); end
    idle(100);
    rd_reg(0, v);
    checks++; if (v !== 32'd1 || v !== exp_data) begin
      fails++; $display("FAIL mtime_100: got %h expected %h", v, 32'd1); end
    idle(899);
    rd_reg(0, v);
    checks++; if (v !== 32'd10 || v !== exp_data) begin
      fails++; $display("FAIL mtime_1000: got %h expected %h", v, 32'd10); end
    checks++; if (mtip_o !== '0 || msip_o !== '0) begin
      fails++; $display("FAIL idle_irq: got mtip=%b msip=%b expected 0", mtip_o, msip_o); end
    rd_reg(8, v);
    checks++; if (v !== 32'd1) begin
      fails++; $display("FAIL ctrl_reset: got %h expected %h", v, 32'd1); end
  endtask

  task automatic test_mtip();
    logic [31:0] v;
    bit found = 0;
    wr_reg(12, 1, 4'hF);
    wr_reg(4, 0, 4'hF);
    wr_reg(0, 0, 4'hF);
    wr_reg(68 + 8, 0, 4'hF);
    wr_reg(64 + 8, 32'h20, 4'hF);
    for (int i = 0; i < 100 && !found; i++) begin
      rd_reg(0, v);
      if (v == 32'h1F) begin
        checks++; if (mtip_o[1] !== 1'b0) begin
          fails++; $display("FAIL mtip_early: got %b expected 0", mtip_o[1]); end
      end
      if (v == 32'h20) begin
        found = 1;
        checks++; if (mtip_o !== 2'b10) begin
          fails++; $display("FAIL mtip_rise: got %b expected %b", mtip_o, 2'b10); end
      end
    end
    checks++; if (!found) begin
      fails++; $display("FAIL mtip_timeout: mtime never read as %h", 32'h20); end
    wr_reg(68 + 8, 1, 4'hF);
    checks++; if (mtip_o[1] !== 1'b1) begin
      fails++; $display("FAIL mtip_hold: got %b expected 1", mtip_o[1]); end
    idle(1);
    checks++; if (mtip_o !== 2'b00 || mtip_o !== exp_mtip) begin
      fails++; $display("FAIL mtip_fall: got %b expected %b", mtip_o, 2'b00); end
  endtask

  task automatic test_atomic();
    logic [31:0] lo, hi;
    wr_reg(4, 0, 4'hF);
    wr_reg(0, 32'hFFFF_FFFE, 4'hF);
    for (int k = 0; k < 3; k++) begin
      rd_reg(0, lo);
      rd_reg(4, hi);
      checks++; if ({hi, lo} !== 64'hFFFF_FFFE + 64'(2*k) || hi !== exp_data) begin
        fails++; $display("FAIL atomic_pair%0d: got %h_%h expected %h", k, hi, lo, 64'hFFFF_FFFE + 64'(2*k)); end
    end
    wr_reg(4, 32'hFFFF_FFFF, 4'hF);
    wr_reg(0, 32'hFFFF_FFFE, 4'hF);
    rd_reg(0, lo);
    rd_reg(4, hi);
    checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      fails++; $display("FAIL wrap_pre: got %h_%h expected %h", hi, lo, 64'hFFFF_FFFF_FFFF_FFFE); end
    rd_reg(0, lo);
    rd_reg(4, hi);
    checks++; if ({hi, lo} !== 64'd0) begin
      fails++; $display("FAIL wrap_zero: got %h_%h expected %h", hi, lo, 64'd0); end
  endtask

  task automatic test_freeze_mask();
    logic [31:0] a, b, c, ea;
    wr_reg(8, 0, 4'hF);
    rd_reg(0, a);
    ea = exp_data;
    idle(9);
    rd_reg(0, b);
    checks++; if (a !== ea || b !== ea) begin
      fails++; $display("FAIL freeze: got %h then %h expected %h", a, b, ea); end
    wr_reg(0, 32'h0000_AB00, 4'b0010);
    rd_reg(0, c);
    checks++; if (c !== {ea[31:16], 8'hAB, ea[7:0]}) begin
      fails++; $display("FAIL byte_mask: got %h expected %h", c, {ea[31:16], 8'hAB, ea[7:0]}); end
    wr_reg(8, 1, 4'hF);
    wr_reg(0, 32'h100, 4'hF);
    wr_reg(4, 32'h5, 4'hF);
    rd_reg(0, a);
    rd_reg(4, b);
    checks++; if (a !== 32'h100 || b !== 32'h5) begin
      fails++; $display("FAIL tick_collide: got %h_%h expected %h_%h", b, a, 32'h5, 32'h100); end
  endtask

  task automatic test_msip();
    logic [31:0] v;
    wr_reg(16, 1, 4'hF);
    wr_reg(20, 32'hFFFF_FFFE, 4'hF);
    checks++; if (msip_o !== 2'b01) begin
      fails++; $display("FAIL msip_out: got %b expected %b", msip_o, 2'b01); end
    rd_reg(20, v);
    checks++; if (v !== 32'd0) begin
      fails++; $display("FAIL msip1_read: got %h expected %h", v, 32'd0); end
    wr_reg(24, 32'hFFFF_FFFF, 4'hF);
    rd_reg(24, v);
    checks++; if (v !== 32'd0 || msip_o !== 2'b01) begin
      fails++; $display("FAIL unmapped_hart: got data=%h msip=%b expected 0 and 01", v, msip_o); end
  endtask

  task automatic test_random();
    int offs [16] = '{0, 4, 8, 12, 16, 20, 24, 32, 60, 64, 68, 72, 76, 80, 84, 96};
    int a, kind;
    logic [31:0] v, d;
    for (int i = 0; i < 400; i++) begin
      a    = offs[$urandom_range(0, 15)] + $urandom_range(0, 3);
      kind = $urandom_range(0, 9);
      if (kind < 4) begin
        d = $urandom;
        if ((a & 32'h7C) == 12) d = $urandom_range(0, 3);
        if ((a & 32'h7C) == 8)  d = {31'b0, ($urandom_range(0, 3) != 0)};
        wr_reg(a, d, 4'($urandom));
      end else if (kind < 8) begin
        rd_reg(a, v);
        checks++; if (v !== exp_data) begin
          fails++; $display("FAIL rand_read%0d addr=%h: got %h expected %h", i, a, v, exp_data); end
      end else begin
        idle(1);
      end
      checks++; if (mtip_o !== exp_mtip || msip_o !== exp_msip) begin
        fails++; $display("FAIL rand_irq%0d: got mtip=%b msip=%b expected %b %b", i, mtip_o, msip_o, exp_mtip, exp_msip); end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    wr_reg(8, 1, 4'hF);
    wr_reg(68, 0, 4'hF);
    wr_reg(64, 0, 4'hF);
    wr_reg(16, 1, 4'hF);
    rd_reg(16, v);
    idle(2);
    checks++; if (mtip_o[0] !== 1'b1 || msip_o[0] !== 1'b1 || data_o !== 32'd1) begin
      fails++; $display("FAIL pre_reset: got mtip=%b msip=%b data=%h expected x1 x1 1", mtip_o, msip_o, data_o); end
    #3;
    reset_i = 0;
    model_reset();
    #1;
    checks++; if (data_o !== 32'd0 || mtip_o !== '0 || msip_o !== '0) begin
      fails++; $display("FAIL async_reset: got data=%h mtip=%b msip=%b expected all zero", data_o, mtip_o, msip_o); end
    @(negedge clk_i);
    reset_i = 1;
    rd_reg(64, v);
    checks++; if (v !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL cmp_after_reset: got %h expected %h", v, 32'hFFFF_FFFF); end
    rd_reg(12, v);
    checks++; if (v !== 32'd100) begin
      fails++; $display("FAIL ps_after_reset: got %h expected %h", v, 32'd100); end
  endtask

  initial begin
    reset_i = 0; csb_i = 1; wen_i = 1; addr_i = 0; data_i = 0; wmask_i = 0;
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1;
    test_reset();
    test_mtip();
    test_atomic();
    test_freeze_mask();
    test_msip();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- Parametrised successor to the single-hart machine timer.
- Provides one shared 64-bit mtime with a programmable prescaler and enable.
- Provides per-hart 64-bit mtimecmp and per-hart software-interrupt (msip) registers.
- Supports atomic 64-bit mtime reads on a 32-bit bus.
- Sits on the core's memory-mapped peripheral port, using the same csb/wen/wmask SRAM-style interface, and drives mtip/msip to each hart's CSR unit.

Parameters:
- NUM_HARTS, 2, number of harts/channels; legal range 1..8.
- PRESCALE_W, 16, width of the prescaler register and counter.
- PRESCALE_RST, 100, reset value of PRESCALE (clock divide ratio).
- ADDR_W, 7, byte-address width.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_i  input  1  asynchronous, active-low reset.
- csb_i  input  1  chip select, active low.
- wen_i  input  1  0 = write, 1 = read; valid only while csb_i = 0.
- addr_i  input  ADDR_W  byte address; addr_i[1:0] ignored (word accesses only).
- data_i  input  32  write data.
- wmask_i  input  4  byte enables; bit n enables data_i[8n+7:8n].
- data_o  output  32  registered read data.
- mtip_o  output  NUM_HARTS  timer interrupt per hart, registered.
- msip_o  output  NUM_HARTS  software interrupt per hart, registered.

Behaviour:
- Register map (byte offsets):
  - 0x00 MTIME_LO
  - 0x04 MTIME_HI
  - 0x08 CTRL: bit0 EN; other bits read 0.
  - 0x0C PRESCALE: PRESCALE_W bits, zero-extended on read.
  - 0x10+4h MSIP[h]: bit0 only.
  - 0x40+8h MTIMECMP_LO[h]
  - 0x44+8h MTIMECMP_HI[h]
  - Offsets for h >= NUM_HARTS and all other offsets are unmapped: reads return 0, writes are ignored.
- Reset values:
  - mtime = 0; every mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, so no spurious interrupt out of reset.
  - msip = 0; EN = 1; PRESCALE = PRESCALE_RST; prescaler counter = 0; shadow = 0.
  - data_o = 0, mtip_o = 0, msip_o = 0.
- Writes (csb_i = 0, wen_i = 0):
  - Byte-masked; bytes with a cleared mask bit keep their value.
  - Take effect at the edge.
- Reads (csb_i = 0, wen_i = 1):
  - data_o is valid one cycle after the request edge and holds until the next read.
  - Writes and idle cycles leave data_o unchanged.
- Atomic mtime read:
  - Reading MTIME_LO returns mtime[31:0] and, on the same edge, copies mtime[63:32] into a 32-bit shadow.
  - Reading MTIME_HI returns the shadow, not the live value.
  - Software reads LO then HI.
  - The shadow is only updated by LO reads, reset, and writes to MTIME_HI (written bytes are mirrored into the shadow).
- Prescaler:
  - When EN = 1, the counter increments each cycle.
  - When the counter reaches PRESCALE-1 it wraps to 0 and generates a one-cycle tick; mtime += 1 on the tick.
  - PRESCALE = 0 or 1: a tick every cycle.
  - When EN = 0, the counter and mtime freeze; the counter is not cleared.
  - Any write to PRESCALE clears the counter to 0 on the same edge.
- mtime arithmetic:
  - 64-bit unsigned; wraps from all-ones to 0 with no flag.
- Simultaneous events:
  - A write to MTIME_LO or MTIME_HI in a tick cycle: the written bytes take the written value, and that tick's increment is dropped for the whole 64-bit register.
  - A read in a tick cycle returns the pre-increment value.
- Interrupts:
  - mtip_o[h] <= (mtime >= mtimecmp[h]), unsigned, evaluated on the current register values. One-cycle latency after any change of mtime or mtimecmp[h].
  - mtip_o is not gated by EN.
  - msip_o[h] <= MSIP[h] bit0, with one-cycle latency after the write.
- Reset asserted mid-operation:
  - All state returns to reset values immediately (asynchronous).
  - Any in-flight read is lost; data_o = 0.

Test Plan:
- Reset then idle with PRESCALE = 100, EN = 1 -> mtime = 1 after 100 cycles, 10 after 1000; mtip_o = 0, msip_o = 0; read CTRL -> 0x1.
- Write PRESCALE = 1, MTIMECMP[1] = 0x0000_0000_0000_0020 (HI first, then LO), then read MTIME_LO until it reaches 0x20 -> mtip_o[1] rises one cycle after mtime becomes 0x20; mtip_o[0] stays 0. Write MTIMECMP_HI[1] = 1 -> mtip_o[1] falls one cycle later.
- Write MTIME = 0x0000_0000_FFFF_FFFE with PRESCALE = 1, then read LO followed by HI across the carry -> the HI read returns the shadow consistent with the LO value (0xFFFF_FFFF + 0 or 0x0000_0001 + 1), never a torn pair. Continue to 64'hFFFF_FFFF_FFFF_FFFF -> mtime wraps to 0.
- With PRESCALE = 1: write CTRL = 0 -> MTIME_LO reads the same value twice 10 cycles apart. Write MTIME_LO with wmask = 4'b0010, data 0xAB00 -> only byte 1 changes. Write coinciding with a tick -> no increment on that edge.
- Write MSIP[0] = 1 and MSIP[1] = 0xFFFF_FFFE -> msip_o = 2'b01 one cycle later; read MSIP[1] -> 0. Write offset 0x18 (h = 2, NUM_HARTS = 2) -> no effect; read returns 0.
- Assert reset_i low asynchronously mid-count with non-zero state -> all outputs 0 immediately; after release, MTIMECMP_LO[0] reads 0xFFFF_FFFF and PRESCALE reads 100.
